// File: rtl/cpu_run_controller.sv
// Run/step/halt/breakpoint controller that gates the CPU clock enable and
// counts enabled cycles and fetched instructions.
module cpu_run_controller #(
    parameter int unsigned DIGIT = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_halt,
    input  logic             clr_cnt,
    input  logic             bp_enable,
    input  logic [DIGIT-1:0] bp_addr,
    input  logic [DIGIT-1:0] pc,
    input  logic             fetch,
    output logic             run,
    output logic [1:0]       state,
    output logic [DIGIT-1:0] cycle_count,
    output logic [DIGIT-1:0] instr_count
);

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StRun   = 2'b01,
        StStep  = 2'b10,
        StBreak = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       btn, btn_q, block_q, press;
    logic             press_run, press_step, press_halt;
    logic             skip_q, skip_d, armed_q, armed_d;
    logic             bp_hit;
    logic [DIGIT-1:0] cycle_q, cycle_d, instr_q, instr_d;

    assign btn = {btn_halt, btn_step, btn_run};

    // block_q masks a button that was already held when reset was applied,
    // so it only counts as pressed after being released once.
    assign press      = btn & ~btn_q & ~block_q;
    assign press_run  = press[0];
    assign press_step = press[1];
    assign press_halt = press[2];

    assign bp_hit = fetch & bp_enable & (pc == bp_addr) & ~skip_q;

    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        unique case (state_q)
            StHalt: begin
                if (!press_halt) begin
                    if (press_run) begin
                        state_d = StRun;
                    end else if (press_step) begin
                        state_d = StStep;
                    end
                end
            end
            StRun: begin
                if (press_halt) begin
                    state_d = StHalt;
                end else if (bp_hit) begin
                    state_d = StBreak;
                end else begin
                    run = 1'b1;
                end
            end
            StStep: begin
                if (press_halt || (fetch && armed_q)) begin
                    state_d = StHalt;
                end else begin
                    run = 1'b1;
                end
            end
            StBreak: begin
                if (press_halt) begin
                    state_d = StHalt;
                end else if (press_run) begin
                    state_d = StRun;
                end else if (press_step) begin
                    state_d = StStep;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    always_comb begin
        skip_d  = skip_q;
        armed_d = armed_q;
        cycle_d = cycle_q;
        instr_d = instr_q;

        // Resuming from a breakpoint must let the breakpointed fetch through once.
        if (state_q == StBreak && (state_d == StRun || state_d == StStep)) begin
            skip_d = 1'b1;
        end else if (fetch && run) begin
            skip_d = 1'b0;
        end

        if (state_d == StStep && state_q != StStep) begin
            armed_d = 1'b0;
        end else if (run) begin
            armed_d = 1'b1;
        end

        if (clr_cnt) begin
            cycle_d = '0;
            instr_d = '0;
        end else begin
            if (run) begin
                cycle_d = cycle_q + DIGIT'(1);
            end
            if (run && fetch) begin
                instr_d = instr_q + DIGIT'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q <= StHalt;
            btn_q   <= 3'b000;
            block_q <= btn;
            skip_q  <= 1'b0;
            armed_q <= 1'b0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn;
            block_q <= block_q & btn;
            skip_q  <= skip_d;
            armed_q <= armed_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign state       = state_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule
